// File: rtl/cl_self_test_if.sv
// Bundles the self-test controller's start/status signals and the logic-unit stimulus/response bits.
// Carries o_err_cnt only when CL_SELF_TEST_ERRCNT_EN is defined.
interface cl_self_test_if;
  logic       i_start;
  logic       o_bit1;
  logic       o_bit2;
  logic       i_and;
  logic       i_nand;
  logic       i_or;
  logic       i_nor;
  logic       i_xor;
  logic       i_xnor;
  logic       i_not;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [6:0] o_fail_vec;
  logic [2:0] dbg_state;
`ifdef CL_SELF_TEST_ERRCNT_EN
  logic [7:0] o_err_cnt;
`endif

  // No valid/ready pair here: i_start is a one-cycle request that is accepted only in IDLE.
  // o_done is a one-cycle completion pulse. o_pass/o_fail_vec stay valid until the next accepted start.
  modport slave (
    input  i_start, i_and, i_nand, i_or, i_nor, i_xor, i_xnor, i_not,
    output o_bit1, o_bit2, o_busy, o_done, o_pass, o_fail_vec, dbg_state
`ifdef CL_SELF_TEST_ERRCNT_EN
    , output o_err_cnt
`endif
  );

  modport master (
    output i_start, i_and, i_nand, i_or, i_nor, i_xor, i_xnor, i_not,
    input  o_bit1, o_bit2, o_busy, o_done, o_pass, o_fail_vec, dbg_state
`ifdef CL_SELF_TEST_ERRCNT_EN
    , input o_err_cnt
`endif
  );
endinterface

// File: rtl/cl_self_test.sv
// Built-in self-test controller for the two-input logic unit: walks 00..11 and checks all seven gates.
// Define CL_SELF_TEST_ERRCNT_EN to add the saturating mismatch counter o_err_cnt.
module cl_self_test #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  cl_self_test_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FINISH} state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec_idx;
  logic [CNT_W-1:0] settle_cnt;
  logic             bit1_q, bit2_q;
  logic [6:0]       fail_q;
  logic             pass_q;
  logic [6:0]       exp_vec, got_vec, mism_vec;

  // Expected values come from the registered stimulus, so they match exactly what the unit sees.
  always_comb begin
    exp_vec = {~bit1_q, ~(bit1_q ^ bit2_q), bit1_q ^ bit2_q, ~(bit1_q | bit2_q),
               bit1_q | bit2_q, ~(bit1_q & bit2_q), bit1_q & bit2_q};
    got_vec = {bus.i_not, bus.i_xnor, bus.i_xor, bus.i_nor, bus.i_or, bus.i_nand, bus.i_and};
    mism_vec = exp_vec ^ got_vec;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = CHECK;
      CHECK:   state_nxt = (vec_idx == 2'd3) ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vec_idx    <= '0;
      settle_cnt <= '0;
      bit1_q     <= 1'b0;
      bit2_q     <= 1'b0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_start) begin
          fail_q  <= '0;
          pass_q  <= 1'b0;
          vec_idx <= '0;
        end
        DRIVE: begin
          {bit1_q, bit2_q} <= vec_idx;
          settle_cnt       <= CNT_W'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
        CHECK: begin
          fail_q <= fail_q | mism_vec;
          if (vec_idx == 2'd3) pass_q <= ((fail_q | mism_vec) == 7'd0);
          else                 vec_idx <= vec_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef CL_SELF_TEST_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [3:0] mism_pop;
  logic [8:0] err_sum;

  always_comb begin
    mism_pop = '0;
    for (int i = 0; i < 7; i++) mism_pop = mism_pop + {3'd0, mism_vec[i]};
    err_sum = {1'b0, err_cnt} + {5'd0, mism_pop};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            err_cnt <= '0;
    else if (state == IDLE && bus.i_start) err_cnt <= '0;
    else if (state == CHECK)               err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign bus.o_err_cnt = err_cnt;
`endif

  assign bus.o_bit1     = bit1_q;
  assign bus.o_bit2     = bit2_q;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_done     = (state == FINISH);
  assign bus.o_pass     = pass_q;
  assign bus.o_fail_vec = fail_q;
  assign bus.dbg_state  = state;

endmodule

// File: doc/cl_self_test.md
Name: cl_self_test

Overview:
- Sequential stimulus/checker for the two-input combinational logic unit.
- Drives the unit's two input bits through all four combinations.
- Samples its seven gate outputs (and, nand, or, nor, xor, xnor, not) and compares each against internally computed expected values.
- Reports per-gate sticky failures plus an overall pass/done status; sits beside the logic unit as its built-in self-test controller.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a vector and sampling the outputs. Legal range 1..255.
- CNT_W, 8: width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle pulse; begins a test run when idle
- o_bit1  out  1  drives the unit's first input bit
- o_bit2  out  1  drives the unit's second input bit
- i_and  in  1  unit AND output
- i_nand  in  1  unit NAND output
- i_or  in  1  unit OR output
- i_nor  in  1  unit NOR output
- i_xor  in  1  unit XOR output
- i_xnor  in  1  unit XNOR output
- i_not  in  1  unit NOT output
- o_busy  out  1  high while a run is in progress
- o_done  out  1  single-cycle pulse at end of run
- o_pass  out  1  valid from o_done until next i_start; 1 = no mismatch in the run
- o_fail_vec  out  7  sticky per-gate mismatch flags. Bit order [6:0] = {not, xnor, xor, nor, or, nand, and}.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0 (o_bit1, o_bit2, o_busy, o_done, o_pass, o_fail_vec); vector index 0; settle counter 0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, FINISH.
- IDLE:
  - i_start=1 -> clear o_fail_vec and o_pass, set vector index 0, go DRIVE.
  - i_start=0 -> stay.
- DRIVE (1 cycle):
  - Register {o_bit1, o_bit2} = vector index (o_bit1 is MSB).
  - Load settle counter with SETTLE_CYCLES-1; go SETTLE.
- SETTLE:
  - Decrement the counter each cycle; go CHECK on the cycle the counter is 0.
  - With SETTLE_CYCLES=1 the block spends exactly one cycle in SETTLE.
- CHECK (1 cycle):
  - Compute expected values from the registered o_bit1/o_bit2: and=a&b, nand=~(a&b), or=a|b, nor=~(a|b), xor=a^b, xnor=~(a^b), not=~a.
  - OR each bit of (expected XOR sampled inputs) into o_fail_vec.
  - Index < 3 -> increment index, go DRIVE. Index = 3 -> go FINISH.
- FINISH (1 cycle):
  - o_done=1.
  - o_pass = (o_fail_vec after the final CHECK == 0).
  - Go IDLE.
- Vector order: 00, 01, 10, 11.
- Run latency, i_start to o_done: 4*(SETTLE_CYCLES+2)+1 cycles. That is 17 cycles at the default.
- o_busy = 1 in DRIVE, SETTLE, CHECK and FINISH.
- o_bit1/o_bit2 hold their last driven value (1,1) after a run until the next DRIVE.
- i_start while busy: ignored, no restart.
- i_start in the same cycle o_done pulses: ignored; a new start requires IDLE.
- o_fail_vec and o_pass hold after FINISH until the next accepted i_start.
- Reset mid-run: immediate abort to reset values, with no o_done pulse.
- Gate inputs are sampled only in CHECK; values in other states have no effect.

Optional Feature:
- Macro: CL_SELF_TEST_ERRCNT_EN.
- Defined:
  - Adds output port o_err_cnt, out, 8 bits: total count of mismatching gate bits in the current run.
  - Each CHECK adds the popcount of the mismatch vector (0..7).
  - Saturates at 255; cleared on accepted i_start and on reset.
  - Holds after FINISH.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Correct unit connected, pulse i_start -> o_busy high for 17 cycles; {o_bit1,o_bit2} walks 00,01,10,11; o_done pulses on cycle 17; o_pass=1; o_fail_vec=7'b0000000.
- i_xor stuck at 0 -> o_fail_vec=7'b0010000, o_pass=0; o_err_cnt=2 when CL_SELF_TEST_ERRCNT_EN is defined (vectors 01 and 10).
- i_not inverted (i_not = i_bit1) and i_and stuck at 1 -> o_fail_vec=7'b1000001, o_pass=0; o_err_cnt=4+3=7 when enabled.
- i_start re-pulsed at cycle 5 of a run -> ignored; o_done still at cycle 17; a second i_start after IDLE clears o_fail_vec and starts a fresh run.
- i_rst asserted during SETTLE of vector 10 -> all outputs 0 immediately, no o_done; the next i_start runs a full 17-cycle test.
- SETTLE_CYCLES=1 -> run latency 13 cycles; every sample taken exactly 2 cycles after the vector is driven.
